// File: rtl/mmul_parallel_mac_engine.sv
// mmul_parallel_mac_engine: two-stage signed MAC datapath for the matrix-multiply HWPE.
// Stage 1 registers the full 2*DATA_W product of one operand pair. Stage 2 either
// passes that product on (simple_mul) or folds it into a 2*DATA_W accumulator. It then
// shifts the value right arithmetically and narrows it into the output register.
// Build macro MMUL_PARALLEL_SATURATE_EN: when defined, the shifted value saturates to
// the signed DATA_W range instead of keeping only its DATA_W LSBs.
// Handshake: a stream transfers in a cycle where its valid and ready are both high.
// in1/in2 only ever transfer together as one pair. A source holding valid keeps its data
// stable until the transfer. The result register keeps out_valid/out_data until
// out_ready, and it only transfers while ctrl_enable is high, because a disabled engine
// freezes all of its state.
module mmul_parallel_mac_engine #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              ctrl_start,
   input  logic              ctrl_clear,
   input  logic              ctrl_enable,
   input  logic              ctrl_simple_mul,
   input  logic [4:0]        ctrl_shift,
   input  logic [CNT_W-1:0]  ctrl_len,
   input  logic [DATA_W-1:0] in1_data,
   input  logic              in1_valid,
   output logic              in1_ready,
   input  logic [DATA_W-1:0] in2_data,
   input  logic              in2_valid,
   output logic              in2_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  flag_cnt,
   output logic              flag_ready,
   output logic              flag_acc_valid,
   output logic [1:0]        dbg_state_o
);

   localparam int unsigned PW = 2 * DATA_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic [CNT_W-1:0]     cnt_q, len_q, cnt_inc;
   logic                 simple_q;
   logic [4:0]           shift_q;
   logic                 s1_valid_q, s1_last_q;
   logic signed [PW-1:0] prod_q, prod_d, acc_q, acc_sum;
   logic signed [PW-1:0] op1_ext, op2_ext;
   logic                 out_valid_q, out_last_q;
   logic [DATA_W-1:0]    out_data_q;

   logic soft_clr, stall, in_ready, fire, last_fire, final_hs, start_ok;

   // Shift, then narrow to DATA_W (saturating or truncating by build option).
   function automatic logic [DATA_W-1:0] fmt_result(input logic signed [PW-1:0] v,
                                                    input logic [4:0] sh);
`ifdef MMUL_PARALLEL_SATURATE_EN
      logic signed [PW-1:0] s;
      logic [PW-DATA_W:0]   top;
      s   = v >>> sh;
      top = s[PW-1:DATA_W-1];
      if ((&top) || (~|top)) return s[DATA_W-1:0];
      else if (s[PW-1])      return {1'b1, {(DATA_W-1){1'b0}}};
      else                   return {1'b0, {(DATA_W-1){1'b1}}};
`else
      return DATA_W'(v >>> sh);
`endif
   endfunction

   assign soft_clr  = ctrl_clear | clear_i;
   assign stall     = out_valid_q & ~out_ready;
   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign fire      = in_ready & in1_valid & in2_valid;
   assign last_fire = fire & (cnt_inc == len_q);
   assign final_hs  = ctrl_enable & out_valid_q & out_ready & out_last_q;
   assign start_ok  = (state_q == IDLE) & ctrl_start & ctrl_enable & (ctrl_len != '0);
   assign op1_ext   = PW'($signed(in1_data));
   assign op2_ext   = PW'($signed(in2_data));
   assign prod_d    = op1_ext * op2_ext;
   assign acc_sum   = acc_q + prod_q;

   // FSM state register; a soft clear wins over everything else.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)       state_q <= IDLE;
      else if (soft_clr) state_q <= IDLE;
      else               state_q <= state_d;
   end

   // FSM next state; nothing moves while the engine is disabled.
   always_comb begin
      state_d = state_q;
      if (ctrl_enable) begin
         unique case (state_q)
            IDLE:    if (start_ok)  state_d = RUN;
            RUN:     if (last_fire) state_d = DRAIN;
            DRAIN:   if (final_hs)  state_d = IDLE;
            default:                state_d = IDLE;
         endcase
      end
   end

   // FSM outputs: operand readiness and status flags.
   always_comb begin
      in_ready       = (state_q == RUN) & ctrl_enable & (cnt_q < len_q) & ~stall;
      flag_ready     = (state_q == IDLE) & ~s1_valid_q & ~out_valid_q;
      flag_acc_valid = final_hs;
      dbg_state_o    = state_q;
   end

   // Job configuration capture and pair counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         len_q    <= '0;
         simple_q <= 1'b0;
         shift_q  <= '0;
      end else if (soft_clr) begin
         cnt_q <= '0;
      end else if (start_ok) begin
         cnt_q    <= '0;
         len_q    <= ctrl_len;
         simple_q <= ctrl_simple_mul;
         shift_q  <= ctrl_shift;
      end else if (fire) begin
         cnt_q <= cnt_inc;
      end
   end

   // Product stage, accumulate/format stage and output register; a stall freezes all.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         prod_q      <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else if (soft_clr) begin
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else if (ctrl_enable) begin
         if (start_ok) acc_q <= '0;
         if (!stall) begin
            s1_valid_q  <= fire;
            s1_last_q   <= last_fire;
            if (fire) prod_q <= prod_d;
            out_valid_q <= 1'b0;
            if (s1_valid_q) begin
               if (simple_q) begin
                  out_valid_q <= 1'b1;
                  out_last_q  <= s1_last_q;
                  out_data_q  <= fmt_result(prod_q, shift_q);
               end else begin
                  acc_q <= acc_sum;
                  if (s1_last_q) begin
                     out_valid_q <= 1'b1;
                     out_last_q  <= 1'b1;
                     out_data_q  <= fmt_result(acc_sum, shift_q);
                  end
               end
            end
         end
      end
   end

   assign in1_ready = in_ready;
   assign in2_ready = in_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign flag_cnt  = cnt_q;

endmodule

// File: doc/mmul_parallel_mac_engine.md
MMUL_PARALLEL_MAC_ENGINE -- requirements
Module: mmul_parallel_mac_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32, signed operand and result width.
REQ-002 SHALL have parameter CNT_W, default 16, width of len and cnt.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear_i  input  1  synchronous soft clear.
REQ-006 SHALL have port ctrl_start/ctrl_clear/ctrl_enable  input  1 each  engine control from the HWPE FSM.
REQ-007 SHALL have port ctrl_simple_mul  input  1  1 = per-element product, 0 = dot-product accumulate.
REQ-008 SHALL have port ctrl_shift  input  5  arithmetic right shift applied to each result.
REQ-009 SHALL have port ctrl_len  input  CNT_W  number of operand pairs per job.
REQ-010 SHALL have ports in1_data/in2_data  input  DATA_W, in1_valid/in2_valid  input  1, in1_ready/in2_ready  output  1  operand streams.
REQ-011 SHALL have ports out_data  output  DATA_W, out_valid  output  1, out_ready  input  1  result stream.
REQ-012 SHALL have ports flag_cnt  output  CNT_W, flag_ready  output  1, flag_acc_valid  output  1  status to FSM.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN.
REQ-014 IDLE -> RUN on ctrl_start & ctrl_enable with ctrl_len > 0; latches len, simple_mul, shift; cnt := 0; ctrl_start with ctrl_len == 0 SHALL stay IDLE, emit nothing.
REQ-015 ctrl_start outside IDLE SHALL be ignored.
REQ-016 in1_ready = in2_ready = (RUN) & ctrl_enable & (cnt < len) & ~stall; stall = out_valid & ~out_ready.
REQ-017 A pair SHALL be consumed only when both valids and both readies are high (fire); no single-stream consumption.
REQ-018 On fire, cnt SHALL increment by 1; flag_cnt = cnt.
REQ-019 Stage 1 SHALL register the full 2*DATA_W signed product; stage 2 SHALL either load it (simple_mul) or add it to a 2*DATA_W signed accumulator cleared at start.
REQ-020 Result SHALL be (value >>> shift) truncated to DATA_W LSBs.
REQ-021 simple_mul: each fired pair SHALL appear on out_data exactly 2 cycles after fire absent stall; len results total, in order.
REQ-022 Accumulate: exactly one result, presented 2 cycles after the last fire absent stall.
REQ-023 RUN -> DRAIN when cnt reaches len; DRAIN -> IDLE in the cycle the last result handshakes (out_valid & out_ready).
REQ-024 out_valid SHALL remain high and out_data stable until out_ready; stall freezes both pipeline stages.
REQ-025 flag_acc_valid SHALL pulse one cycle when the final result of a job handshakes.
REQ-026 flag_ready SHALL be 1 iff state == IDLE and no valid data in the pipeline.
REQ-027 ctrl_enable low SHALL freeze all state (cnt, pipeline, FSM), deassert in*_ready; out_valid held.
REQ-028 ctrl_clear or clear_i SHALL, in the next cycle, force IDLE, cnt := 0, accumulator 0, out_valid 0, dropping in-flight data; has priority over start/enable.

Reset
REQ-029 On rst_ni low: state IDLE, cnt 0, accumulator 0, pipeline valids 0, out_valid 0, out_data 0, in*_ready 0, flag_ready 1, flag_acc_valid 0.
REQ-030 Reset mid-job SHALL abandon the job; no result emitted after release.

Configuration
REQ-031 Macro MMUL_PARALLEL_SATURATE_EN: when defined, shifted result SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; when undefined, plain LSB truncation per REQ-020.

Verification
REQ-032 simple_mul, len=4, shift=0, in1={1,2,-3,4}, in2={5,6,7,-8}, out_ready=1 -> out {5,12,-21,-32}, flag_cnt ends 4, one acc_valid pulse.
REQ-033 accumulate, len=3, shift=2, in1={4,4,4}, in2={1,2,3} -> single out 6, then IDLE, flag_ready=1.
REQ-034 simple_mul len=3, out_ready low 5 cycles after first result -> out_data held constant, in*_ready 0, no loss/duplication.
REQ-035 in1_valid=1, in2_valid=0 for 4 cycles -> no fire, cnt unchanged; then in2_valid=1 -> fire.
REQ-036 ctrl_clear at cnt=2 of len=5 -> IDLE next cycle, out_valid 0, cnt 0; new job runs correctly.
REQ-037 accumulate, in1=in2=0x7FFFFFFF, len=2, shift=0 -> with MMUL_PARALLEL_SATURATE_EN out 0x7FFFFFFF; without, truncated LSBs 0x00000002.
